inv_checker: RTL and testbench
==============================

# inv_checker

Self-checking response monitor for the inverter datapath. It is the receiving end of the inverter stimulus interface: the stimulus side drives `A` and the checker samples both the DUT input and output. It compares `Y` against `~A` after a configurable pipeline latency, counts checks and mismatches, captures the index of the first failure, and raises `done`/`pass` at the end of a run. It is used in inverter benches and in on-chip built-in self-test (BIST) wrappers.

## Interface
- `LATENCY`, default 0: cycles between the DUT input and its output; legal range 0–7.
- `NUM_CHECKS`, default 16: number of compared samples per run; must be at least 1.
- `CNT_W`, default 16: width of `chk_cnt` and `first_err_idx`; must satisfy 2^CNT_W > NUM_CHECKS.
- `ERR_W`, default 8: width of `err_cnt`; the counter saturates.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begins a run; sampled only in IDLE or DONE.
- `a_in`, in, 1: DUT input (`A`), the same signal the stimulus drives.
- `y_in`, in, 1: DUT output (`Y`).
- `busy`, out, 1: high in FILL and CHECK.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: valid while `done` is high; 1 if `err_cnt` is 0.
- `chk_cnt`, out, CNT_W: number of comparisons performed in the current run.
- `err_cnt`, out, ERR_W: number of mismatches, saturating at all-ones.
- `first_err_valid`, out, 1: at least one mismatch has been seen in this run.
- `first_err_idx`, out, CNT_W: value of `chk_cnt` at the first mismatch.

## Operation
- There are four states: IDLE, FILL, CHECK and DONE.
- Reset forces IDLE and clears the delay line. All outputs reset to 0.
- **IDLE**: `start`=1 at an edge clears every counter, `first_err_*` and the delay line. The next state is FILL if LATENCY>0, otherwise CHECK.
- **Delay line**: this is a LATENCY-deep shift register. `a_in` is shifted in on every FILL and CHECK edge.
- **Expected value**: `exp` = ~`a_in` when LATENCY=0. Otherwise `exp` = ~(the entry shifted in LATENCY edges earlier).
- **FILL**:
  - No comparison is made.
  - A fill counter runs from 0 to LATENCY-1.
  - After LATENCY edges the state moves to CHECK.
- **CHECK**: at each edge the checker compares `y_in` with `exp`.
  - `chk_cnt` increments on every compare.
  - On a mismatch, `err_cnt` increments unless it is all-ones.
  - On the first mismatch, `first_err_valid` is set to 1 and `first_err_idx` loads the pre-increment `chk_cnt`.
  - On the edge that performs compare number NUM_CHECKS, the state moves to DONE.
- **Unknown values**: an X or Z on `y_in` counts as a mismatch in simulation. The comparison is written so that an unknown `y_in` never counts as a match.
- **DONE**:
  - `done`=1 and `pass`=(`err_cnt`==0).
  - All counters hold their values.
  - `start`=1 starts a new run, with the same clearing as in IDLE. Otherwise the state holds indefinitely.
- `start` is ignored in FILL and CHECK; a running check cannot be aborted except by reset.
- Reset asserted mid-run clears everything immediately, with no partial results retained. Run data is lost.

## Timing
- `start` is sampled at edge t. Then:
  - The first delay-line shift happens at edge t+1.
  - The first compare happens at edge t+1+LATENCY.
  - The last compare happens at edge t+LATENCY+NUM_CHECKS.
- `done` rises right after the last-compare edge.
- `busy` is high for exactly LATENCY+NUM_CHECKS cycles per run.
- All outputs are registered and change only on `clk` edges or on `rst`.
- `a_in` and `y_in` are sampled at the rising edge. The bench changes them at least 1 ns before the edge, so sampling is race-free with the stimulus' nonblocking drives.
- The run length is the same whether mismatches occur or not; an error does not end the run early.

## Test plan
- **Clean run**: LATENCY=0, NUM_CHECKS=4, `a_in` driven 0,1,0,1 on successive cycles through a combinational inverter.
  - Required: `done` after 4 busy cycles, `pass`=1, `err_cnt`=0, `chk_cnt`=4, `first_err_valid`=0.
- **Stuck-wire fault**: LATENCY=0, NUM_CHECKS=4, `y_in` tied to `a_in`.
  - Required: `err_cnt`=4, `first_err_valid`=1, `first_err_idx`=0, `pass`=0.
- **Single glitch and latency**: NUM_CHECKS=8, `y_in` flipped only on compare index 2.
  - Required: `err_cnt`=1, `first_err_idx`=2.
  - With LATENCY=2 and a 2-stage registered inverter: `pass`=1 and `busy` high for 10 cycles.
  - With LATENCY=1 and the same inverter, alternating `a_in`: `err_cnt`=8.
- **Saturation**: ERR_W=2, NUM_CHECKS=8, every compare wrong.
  - Required: `err_cnt`=3, `chk_cnt`=8, `pass`=0.
- **Start handling**:
  - A `start` pulse mid-CHECK is ignored: `chk_cnt` still ends at NUM_CHECKS.
  - `start` held in DONE begins a new run, with counters cleared on the next edge.
- **Reset mid-run**: assert `rst` asynchronously mid-CHECK, 3 ns after an edge, with errors already counted.
  - Required: all outputs go to 0 immediately, with no clock edge needed.
  - After release, the checker stays in IDLE until `start`.

Source files
------------

// File: rtl/inv_checker.sv
// Response monitor for an inverter datapath: compares y_in against ~a_in delayed by
// LATENCY cycles over NUM_CHECKS samples and reports counts, first failure and pass/fail.
module inv_checker #(
    parameter int LATENCY    = 0,
    parameter int NUM_CHECKS = 16,
    parameter int CNT_W      = 16,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_in,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int         DLY_W     = (LATENCY > 0) ? LATENCY : 1;
    localparam logic [2:0] FILL_LAST = 3'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(NUM_CHECKS - 1);

    // state is the FSM observation point for bound checkers
    logic [1:0]       state;
    logic [2:0]       fill_cnt;
    logic [DLY_W-1:0] dly;
    logic             exp_bit;

    // dly[LATENCY-1] holds the a_in sample taken LATENCY edges ago
    assign exp_bit = (LATENCY == 0) ? ~a_in : ~dly[DLY_W-1];

    assign busy = (state == S_FILL) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            fill_cnt        <= '0;
            dly             <= '0;
            chk_cnt         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state           <= (LATENCY > 0) ? S_FILL : S_CHECK;
                        fill_cnt        <= '0;
                        dly             <= '0;
                        chk_cnt         <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                    end
                end
                S_FILL: begin
                    dly[0] <= a_in;
                    for (int i = 1; i < DLY_W; i++) dly[i] <= dly[i-1];
                    if (fill_cnt == FILL_LAST) state <= S_CHECK;
                    else fill_cnt <= fill_cnt + 3'd1;
                end
                S_CHECK: begin
                    dly[0] <= a_in;
                    for (int i = 1; i < DLY_W; i++) dly[i] <= dly[i-1];
                    chk_cnt <= chk_cnt + 1'b1;
                    // Error path sits in the else so an X/Z y_in falls into it
                    if (y_in == exp_bit) begin
                        err_cnt <= err_cnt;
                    end else begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= chk_cnt;
                        end
                    end
                    if (chk_cnt == CHK_LAST) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_checker.sv
// Directed bench for inv_checker: four instances cover zero latency, latency 1 and 2
// with a registered inverter, and a 2-bit saturating error counter.
module tb_inv_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]       start_v  = '0;
    logic [3:0]       a_v      = '0;
    logic [3:0]       glitch_v = '0;
    logic [3:0]       y_v;
    logic             stuck0   = 1'b0;
    logic [3:0]       r1, r2;
    logic [3:0]       busy_v, done_v, pass_v, fev_v;
    logic [3:0][15:0] chk_v, fei_v;
    logic [3:0][7:0]  err_v;
    logic [1:0]       err3;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;

    // two-stage registered inverter used by the latency instances
    always @(posedge clk) begin
        r1 <= ~a_v;
        r2 <= r1;
    end

    always_comb begin
        y_v    = '0;
        y_v[0] = stuck0 ? a_v[0] : ~a_v[0];
        y_v[1] = r2[1] ^ glitch_v[1];
        y_v[2] = r2[2];
        y_v[3] = a_v[3];
    end

    assign err_v[3] = {6'b0, err3};

    inv_checker #(.LATENCY(0), .NUM_CHECKS(4)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .y_in(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .chk_cnt(chk_v[0]),
        .err_cnt(err_v[0]), .first_err_valid(fev_v[0]), .first_err_idx(fei_v[0]));

    inv_checker #(.LATENCY(2), .NUM_CHECKS(8)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .y_in(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .chk_cnt(chk_v[1]),
        .err_cnt(err_v[1]), .first_err_valid(fev_v[1]), .first_err_idx(fei_v[1]));

    inv_checker #(.LATENCY(1), .NUM_CHECKS(8)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a_in(a_v[2]), .y_in(y_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .chk_cnt(chk_v[2]),
        .err_cnt(err_v[2]), .first_err_valid(fev_v[2]), .first_err_idx(fei_v[2]));

    inv_checker #(.LATENCY(0), .NUM_CHECKS(8), .ERR_W(2)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a_in(a_v[3]), .y_in(y_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .chk_cnt(chk_v[3]),
        .err_cnt(err3), .first_err_valid(fev_v[3]), .first_err_idx(fei_v[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    // Pulse start on instance u, then drive pattern bits until done; counts busy cycles.
    task automatic run(input int u, input logic [15:0] pat, input int mid_start,
                       input int glitch_i, output int busy_cycles);
        @(negedge clk);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_v[u]) break;
            a_v[u]      = pat[i[3:0]];
            start_v[u]  = (i == mid_start);
            glitch_v[u] = (i == glitch_i);
            if (busy_v[u]) busy_cycles++;
            @(negedge clk);
        end
        start_v[u]  = 1'b0;
        glitch_v[u] = 1'b0;
        check("run_done", {31'b0, done_v[u]}, 32'd1);
    endtask

    initial begin
        #3;
        check("rst_busy", {28'b0, busy_v}, 0);
        check("rst_done", {28'b0, done_v}, 0);
        check("rst_pass", {28'b0, pass_v}, 0);
        check("rst_chk",  {16'b0, chk_v[0]}, 0);
        check("rst_err",  {24'b0, err_v[0]}, 0);
        check("rst_fev",  {28'b0, fev_v}, 0);
        check("rst_fei",  {16'b0, fei_v[0]}, 0);
        @(negedge clk);
        rst = 1'b0;

        // clean run, 0,1,0,1
        run(0, 16'hAAAA, -1, -1, cyc);
        check("clean_busy", cyc, 4);
        check("clean_pass", {31'b0, pass_v[0]}, 1);
        check("clean_err",  {24'b0, err_v[0]}, 0);
        check("clean_chk",  {16'b0, chk_v[0]}, 4);
        check("clean_fev",  {31'b0, fev_v[0]}, 0);

        // start pulse mid-CHECK is ignored
        run(0, 16'h0005, 1, -1, cyc);
        check("mid_busy", cyc, 4);
        check("mid_chk",  {16'b0, chk_v[0]}, 4);
        check("mid_pass", {31'b0, pass_v[0]}, 1);

        // stuck wire: y tied to a
        stuck0 = 1'b1;
        run(0, 16'h0009, -1, -1, cyc);
        check("stuck_err",  {24'b0, err_v[0]}, 4);
        check("stuck_fev",  {31'b0, fev_v[0]}, 1);
        check("stuck_fei",  {16'b0, fei_v[0]}, 0);
        check("stuck_pass", {31'b0, pass_v[0]}, 0);
        check("stuck_chk",  {16'b0, chk_v[0]}, 4);

        // start held in DONE restarts with cleared counters
        stuck0 = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        check("hold_busy", {31'b0, busy_v[0]}, 1);
        check("hold_chk0", {16'b0, chk_v[0]}, 0);
        check("hold_err0", {24'b0, err_v[0]}, 0);
        check("hold_fev0", {31'b0, fev_v[0]}, 0);
        @(negedge clk);
        check("hold_chk1", {16'b0, chk_v[0]}, 1);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_done", {31'b0, done_v[0]}, 1);
        check("hold_pass", {31'b0, pass_v[0]}, 1);

        // latency 2, registered inverter, clean then glitch on compare index 2
        run(1, 16'hB4D2, -1, -1, cyc);
        check("l2_busy", cyc, 10);
        check("l2_pass", {31'b0, pass_v[1]}, 1);
        check("l2_chk",  {16'b0, chk_v[1]}, 8);
        run(1, 16'h3C5A, -1, 4, cyc);
        check("gl_err",  {24'b0, err_v[1]}, 1);
        check("gl_fev",  {31'b0, fev_v[1]}, 1);
        check("gl_fei",  {16'b0, fei_v[1]}, 2);
        check("gl_pass", {31'b0, pass_v[1]}, 0);

        // latency 1 against a 2-stage inverter, alternating a
        a_v[2] = 1'b1;
        run(2, 16'hAAAA, -1, -1, cyc);
        check("l1_busy", cyc, 9);
        check("l1_err",  {24'b0, err_v[2]}, 8);
        check("l1_fei",  {16'b0, fei_v[2]}, 0);

        // saturation with 2-bit error counter
        run(3, 16'h1234, -1, -1, cyc);
        check("sat_err",  {24'b0, err_v[3]}, 3);
        check("sat_chk",  {16'b0, chk_v[3]}, 8);
        check("sat_pass", {31'b0, pass_v[3]}, 0);

        // asynchronous reset mid-CHECK with errors already counted
        stuck0 = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_err", {24'b0, err_v[0]}, 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy_v[0]}, 0);
        check("arst_err",  {24'b0, err_v[0]}, 0);
        check("arst_chk",  {16'b0, chk_v[0]}, 0);
        check("arst_fev",  {31'b0, fev_v[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'b0, busy_v[0]}, 0);
        check("idle_done", {31'b0, done_v[0]}, 0);
        check("idle_chk",  {16'b0, chk_v[0]}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
